floo_route_arb: RTL and testbench



---
 rtl/floo_pkg.sv | 37 +++
 rtl/floo_route_comp.sv | 57 +++++
 rtl/floo_route_arb.sv | 161 ++++++++++++++++
 tb/tb_floo_route_arb.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/floo_pkg.sv
// rtl/floo_pkg.sv - shared routing types, route config and route-arbiter FSM states
package floo_pkg;

  typedef enum logic {
    IdTable,
    SourceRouting
  } route_algo_e;

  typedef struct packed {
    route_algo_e RouteAlgo;
    logic        UseIdTable;
    int unsigned NumSamRules;
    int unsigned NumRoutes;
  } route_cfg_t;

  typedef logic [3:0]  floo_id_t;
  typedef logic [31:0] floo_addr_t;
  typedef logic [7:0]  floo_route_t;

  typedef struct packed {
    floo_id_t   idx;
    floo_addr_t start_addr;
    floo_addr_t end_addr;
  } floo_sam_rule_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    CFG
  } route_arb_state_e;

  // Table ports keep at least one entry so a zeroed config still elaborates.
  function automatic int unsigned at_least_one(int unsigned n);
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/floo_route_comp.sv
// rtl/floo_route_comp.sv - combinational SAM decode and source-route lookup for one request
module floo_route_comp import floo_pkg::*; #(
  parameter route_cfg_t RouteCfg    = '0,
  parameter bit         EnMultiCast = 1'b0,
  parameter type        id_t        = floo_id_t,
  parameter type        addr_t      = floo_addr_t,
  parameter type        route_t     = floo_route_t,
  parameter type        addr_rule_t = floo_sam_rule_t
) (
  input  logic                                                 clk_i,
  input  logic                                                 rst_ni,
  input  id_t                                                  id_i,
  input  addr_t                                                addr_i,
  input  addr_rule_t [at_least_one(RouteCfg.NumSamRules)-1:0]  addr_map_i,
  input  route_t     [at_least_one(RouteCfg.NumRoutes)-1:0]    route_table_i,
  input  id_t                                                  mask_i,
  input  id_t                                                  mask_map_i,
  output id_t                                                  id_o,
  output route_t                                               route_o,
  output id_t                                                  mask_o
);

  localparam int unsigned NumRules  = at_least_one(RouteCfg.NumSamRules);
  localparam int unsigned NumRoutes = at_least_one(RouteCfg.NumRoutes);
  localparam bit          UseTable  = (RouteCfg.RouteAlgo == IdTable) || RouteCfg.UseIdTable;

  id_t  sam_id;
  id_t  dst_id;
  logic unused_clk_rst;

  assign unused_clk_rst = clk_i ^ rst_ni;

  // Lowest-indexed matching rule wins when rules overlap.
  always_comb begin
    sam_id = '0;
    for (int i = NumRules - 1; i >= 0; i--) begin
      if (addr_i >= addr_map_i[i].start_addr && addr_i < addr_map_i[i].end_addr) begin
        sam_id = addr_map_i[i].idx;
      end
    end
  end

  assign dst_id = UseTable ? sam_id : id_i;

  always_comb begin
    route_o = '0;
    if (RouteCfg.RouteAlgo == SourceRouting) begin
      for (int unsigned r = 0; r < NumRoutes; r++) begin
        if (dst_id == id_t'(r)) route_o = route_table_i[r];
      end
    end
  end

  assign id_o   = dst_id;
  assign mask_o = EnMultiCast ? (mask_i & mask_map_i) : '0;

endmodule

// File: rtl/floo_route_arb.sv
// rtl/floo_route_arb.sv - round-robin sharing of one route lookup among NumReq requesters,
// with a registered result stage and a drain/freeze handshake for table updates
module floo_route_arb import floo_pkg::*; #(
  parameter route_cfg_t  RouteCfg    = '0,
  parameter int unsigned NumReq      = 2,
  parameter type         id_t        = floo_id_t,
  parameter type         addr_t      = floo_addr_t,
  parameter type         route_t     = floo_route_t,
  parameter type         addr_rule_t = floo_sam_rule_t,
  parameter int unsigned IdxW        = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                                                 clk_i,
  input  logic                                                 rst_ni,
  input  logic       [NumReq-1:0]                              req_valid_i,
  output logic       [NumReq-1:0]                              req_ready_o,
  input  addr_t      [NumReq-1:0]                              req_addr_i,
  input  id_t        [NumReq-1:0]                              req_id_i,
  input  addr_rule_t [at_least_one(RouteCfg.NumSamRules)-1:0]  addr_map_i,
  input  route_t     [at_least_one(RouteCfg.NumRoutes)-1:0]    route_table_i,
  output logic                                                 rsp_valid_o,
  input  logic                                                 rsp_ready_i,
  output logic       [IdxW-1:0]                                rsp_idx_o,
  output id_t                                                  rsp_id_o,
  output route_t                                               rsp_route_o,
  input  logic                                                 cfg_req_i,
  output logic                                                 cfg_gnt_o
);

  route_arb_state_e state_q, state_d;
  logic [IdxW-1:0]  prio_q, prio_d, gnt_idx_q, gnt_idx_d;
  logic             lock_q, lock_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IdxW-1:0]  rsp_idx_q, rsp_idx_d;
  id_t              rsp_id_q, rsp_id_d;
  route_t           rsp_route_q, rsp_route_d;

  logic [IdxW-1:0]  sel_idx;
  logic             sel_valid, out_free, accept;
  int unsigned      cand;
  id_t              comp_id, mask_unused;
  route_t           comp_route;

  // A locked grant is held; otherwise search from prio_q, wrapping modulo NumReq.
  always_comb begin
    sel_idx   = prio_q;
    sel_valid = 1'b0;
    cand      = 0;
    if (lock_q) begin
      sel_idx   = gnt_idx_q;
      sel_valid = req_valid_i[gnt_idx_q];
    end else begin
      for (int unsigned k = 0; k < NumReq; k++) begin
        cand = 32'(prio_q) + k;
        if (cand >= NumReq) cand = cand - NumReq;
        if (!sel_valid && req_valid_i[IdxW'(cand)]) begin
          sel_valid = 1'b1;
          sel_idx   = IdxW'(cand);
        end
      end
    end
  end

  assign out_free = !rsp_valid_q || rsp_ready_i;
  assign accept   = (state_q == RUN) && sel_valid && out_free;

  always_comb begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      req_ready_o[i] = accept && (sel_idx == IdxW'(i));
    end
  end

  floo_route_comp #(
    .RouteCfg    (RouteCfg),
    .EnMultiCast (1'b0),
    .id_t        (id_t),
    .addr_t      (addr_t),
    .route_t     (route_t),
    .addr_rule_t (addr_rule_t)
  ) i_route_comp (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .id_i          (req_id_i[sel_idx]),
    .addr_i        (req_addr_i[sel_idx]),
    .addr_map_i    (addr_map_i),
    .route_table_i (route_table_i),
    .mask_i        ('0),
    .mask_map_i    ('0),
    .id_o          (comp_id),
    .route_o       (comp_route),
    .mask_o        (mask_unused)
  );

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    lock_d      = lock_q;
    gnt_idx_d   = gnt_idx_q;
    rsp_valid_d = rsp_valid_q && !rsp_ready_i;
    rsp_idx_d   = rsp_idx_q;
    rsp_id_d    = rsp_id_q;
    rsp_route_d = rsp_route_q;
    unique case (state_q)
      RUN: begin
        if (accept) begin
          rsp_valid_d = 1'b1;
          rsp_idx_d   = sel_idx;
          rsp_id_d    = comp_id;
          rsp_route_d = comp_route;
          prio_d      = (sel_idx == IdxW'(NumReq - 1)) ? '0 : sel_idx + IdxW'(1);
          lock_d      = 1'b0;
        end else begin
          lock_d    = sel_valid;
          gnt_idx_d = sel_idx;
        end
        // Entering DRAIN releases any stalled grant; the requester simply keeps its valid.
        if (cfg_req_i) begin
          state_d = DRAIN;
          lock_d  = 1'b0;
        end
      end
      DRAIN: begin
        lock_d = 1'b0;
        if (!cfg_req_i)    state_d = RUN;
        else if (out_free) state_d = CFG;
      end
      CFG: begin
        if (!cfg_req_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      prio_q      <= '0;
      lock_q      <= 1'b0;
      gnt_idx_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_id_q    <= '0;
      rsp_route_q <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      lock_q      <= lock_d;
      gnt_idx_q   <= gnt_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_id_q    <= rsp_id_d;
      rsp_route_q <= rsp_route_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_idx_o   = rsp_idx_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_route_o = rsp_route_q;
  assign cfg_gnt_o   = (state_q == CFG);

endmodule

// File: tb/tb_floo_route_arb.sv
// tb/tb_floo_route_arb.sv - directed checks of arbitration, stalls, cfg handshake, source routing and reset
module tb_floo_route_arb;
  import floo_pkg::*;

  localparam route_cfg_t CfgId = '{RouteAlgo: IdTable, UseIdTable: 1'b1,
                                   NumSamRules: 32'd1, NumRoutes: 32'd1};
  localparam route_cfg_t CfgSr = '{RouteAlgo: SourceRouting, UseIdTable: 1'b0,
                                   NumSamRules: 32'd1, NumRoutes: 32'd4};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                     valid_a, rsp_valid_a, rsp_ready_a, cfg_req_a, cfg_gnt_a;
  logic [1:0]               req_valid_a, req_ready_a;
  floo_addr_t  [1:0]        addr_a;
  floo_id_t    [1:0]        id_a;
  floo_sam_rule_t [0:0]     map_a;
  floo_route_t [0:0]        rt_a;
  logic [0:0]               idx_a;
  floo_id_t                 rsp_id_a;
  floo_route_t              rsp_route_a;

  logic [1:0]               sr_valid, sr_ready;
  floo_addr_t  [1:0]        sr_addr;
  floo_id_t    [1:0]        sr_id;
  floo_sam_rule_t [0:0]     map_sr;
  floo_route_t [3:0]        rt_sr;
  logic                     sr_rsp_valid, sr_rsp_ready, sr_cfg_req, sr_cfg_gnt;
  logic [0:0]               sr_idx;
  floo_id_t                 sr_rsp_id;
  floo_route_t              sr_route;

  int tests_run = 0;
  int failures  = 0;

  floo_route_arb #(
    .RouteCfg(CfgId), .NumReq(2), .id_t(floo_id_t), .addr_t(floo_addr_t),
    .route_t(floo_route_t), .addr_rule_t(floo_sam_rule_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid_a), .req_ready_o(req_ready_a),
    .req_addr_i(addr_a), .req_id_i(id_a),
    .addr_map_i(map_a), .route_table_i(rt_a),
    .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready_a),
    .rsp_idx_o(idx_a), .rsp_id_o(rsp_id_a), .rsp_route_o(rsp_route_a),
    .cfg_req_i(cfg_req_a), .cfg_gnt_o(cfg_gnt_a)
  );

  floo_route_arb #(
    .RouteCfg(CfgSr), .NumReq(2), .id_t(floo_id_t), .addr_t(floo_addr_t),
    .route_t(floo_route_t), .addr_rule_t(floo_sam_rule_t)
  ) dut_sr (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(sr_valid), .req_ready_o(sr_ready),
    .req_addr_i(sr_addr), .req_id_i(sr_id),
    .addr_map_i(map_sr), .route_table_i(rt_sr),
    .rsp_valid_o(sr_rsp_valid), .rsp_ready_i(sr_rsp_ready),
    .rsp_idx_o(sr_idx), .rsp_id_o(sr_rsp_id), .rsp_route_o(sr_route),
    .cfg_req_i(sr_cfg_req), .cfg_gnt_o(sr_cfg_gnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    valid_a      = 1'b0;
    req_valid_a  = 2'b00;
    rsp_ready_a  = 1'b1;
    cfg_req_a    = 1'b0;
    addr_a       = '0;
    id_a         = '0;
    map_a[0]     = '{idx: 4'd3, start_addr: 32'h1000, end_addr: 32'h2000};
    rt_a         = '0;
    sr_valid     = 2'b00;
    sr_addr      = '0;
    sr_id        = '0;
    map_sr[0]    = '{idx: 4'd7, start_addr: 32'h0, end_addr: 32'h10};
    rt_sr        = {8'h3C, 8'hA5, 8'h22, 8'h11};
    sr_rsp_ready = 1'b1;
    sr_cfg_req   = 1'b0;

    step();
    step();
    check("reset_rsp_valid", rsp_valid_a, 0);
    check("reset_rsp_idx", idx_a, 0);
    check("reset_rsp_id", rsp_id_a, 0);
    check("reset_rsp_route", rsp_route_a, 0);
    check("reset_req_ready", req_ready_a, 0);
    check("reset_cfg_gnt", cfg_gnt_a, 0);
    rst_n = 1'b1;

    // single request from req0
    step();
    req_valid_a = 2'b01;
    addr_a[0]   = 32'h1800;
    addr_a[1]   = 32'h3000;
    #1 check("first_ready", req_ready_a, 2'b01);
    step();
    check("first_rsp_valid", rsp_valid_a, 1);
    check("first_rsp_idx", idx_a, 0);
    check("first_rsp_id", rsp_id_a, 3);
    check("first_rsp_route", rsp_route_a, 0);

    // both valid, back-to-back; pointer now sits at 1
    req_valid_a = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 check("rr_ready", req_ready_a, (k % 2 == 0) ? 2'b10 : 2'b01);
      step();
      check("rr_rsp_valid", rsp_valid_a, 1);
      check("rr_rsp_idx", idx_a, (k % 2 == 0) ? 1 : 0);
      check("rr_rsp_id", rsp_id_a, (k % 2 == 0) ? 0 : 3);
    end

    // stall with req1 waiting
    req_valid_a = 2'b01;
    #1 check("stall_pre_ready", req_ready_a, 2'b01);
    step();
    req_valid_a = 2'b10;
    rsp_ready_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 check("stall_ready", req_ready_a, 2'b00);
      step();
      check("stall_rsp_valid", rsp_valid_a, 1);
      check("stall_rsp_idx", idx_a, 0);
      check("stall_rsp_id", rsp_id_a, 3);
    end
    rsp_ready_a = 1'b1;
    #1 check("stall_release_ready", req_ready_a, 2'b10);
    step();
    check("stall_release_idx", idx_a, 1);
    check("stall_release_id", rsp_id_a, 0);

    // lock: req1 stalled, req0 arrives with pointer at 0 and must not pre-empt
    rsp_ready_a = 1'b0;
    req_valid_a = 2'b10;
    step();
    req_valid_a = 2'b11;
    rsp_ready_a = 1'b1;
    #1 check("lock_hold_ready", req_ready_a, 2'b10);
    step();
    check("lock_hold_idx", idx_a, 1);

    // cfg request in the same cycle as an accept, then drain and freeze
    req_valid_a = 2'b01;
    cfg_req_a   = 1'b1;
    #1 check("cfg_same_cycle_ready", req_ready_a, 2'b01);
    step();
    check("cfg_same_cycle_rsp_valid", rsp_valid_a, 1);
    check("cfg_same_cycle_idx", idx_a, 0);
    check("cfg_gnt_drain1", cfg_gnt_a, 0);
    rsp_ready_a = 1'b0;
    #1 check("drain_ready_stalled", req_ready_a, 2'b00);
    step();
    check("cfg_gnt_drain2", cfg_gnt_a, 0);
    check("drain_rsp_valid", rsp_valid_a, 1);
    rsp_ready_a = 1'b1;
    #1 check("drain_ready_free", req_ready_a, 2'b00);
    step();
    check("cfg_gnt_set", cfg_gnt_a, 1);
    check("cfg_rsp_valid", rsp_valid_a, 0);
    #1 check("cfg_ready", req_ready_a, 2'b00);
    map_a[0].idx = 4'd5;
    cfg_req_a    = 1'b0;
    #1 check("cfg_gnt_hold", cfg_gnt_a, 1);
    step();
    check("cfg_gnt_clear", cfg_gnt_a, 0);
    #1 check("post_cfg_ready", req_ready_a, 2'b01);
    step();
    check("post_cfg_idx", idx_a, 0);
    check("post_cfg_id", rsp_id_a, 5);

    // cfg dropped during DRAIN returns straight to RUN
    req_valid_a = 2'b00;
    rsp_ready_a = 1'b0;
    cfg_req_a   = 1'b1;
    step();
    cfg_req_a = 1'b0;
    step();
    check("abort_cfg_gnt", cfg_gnt_a, 0);
    rsp_ready_a = 1'b1;
    req_valid_a = 2'b10;
    addr_a[1]   = 32'h1800;
    #1 check("abort_ready", req_ready_a, 2'b10);
    step();
    check("abort_idx", idx_a, 1);
    check("abort_id", rsp_id_a, 5);

    // source routing without ID table
    sr_id[0] = 4'd3;
    sr_id[1] = 4'd2;
    sr_valid = 2'b10;
    #1 check("sr_ready", sr_ready, 2'b10);
    step();
    sr_valid = 2'b00;
    check("sr_rsp_valid", sr_rsp_valid, 1);
    check("sr_route", sr_route, 8'hA5);
    check("sr_idx", sr_idx, 1);
    check("sr_id", sr_rsp_id, 2);

    // asynchronous reset with a pending result
    req_valid_a = 2'b00;
    rsp_ready_a = 1'b0;
    step();
    check("prereset_rsp_valid", rsp_valid_a, 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_rsp_valid", rsp_valid_a, 0);
    check("async_reset_idx", idx_a, 0);
    check("async_reset_id", rsp_id_a, 0);
    step();
    rst_n       = 1'b1;
    req_valid_a = 2'b11;
    rsp_ready_a = 1'b1;
    #1 check("post_reset_ready", req_ready_a, 2'b01);
    step();
    check("post_reset_idx", idx_a, 0);
    check("post_reset_rsp_valid", rsp_valid_a, 1);
    req_valid_a = 2'b00;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
